// File: rtl/seven_segment_reader.sv
// rtl/seven_segment_reader.sv - recovers hex digit frames from a multiplexed seven-segment bus
module seven_segment_reader #(
    parameter int DIGITS        = 4,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [7:0]            segments,
    input  logic [DIGITS-1:0]     digit_sel,
    input  logic                  clear,
    output logic [4*DIGITS-1:0]   value,
    output logic [DIGITS-1:0]     dp,
    output logic [DIGITS-1:0]     err_digit,
    output logic                  valid
);

    localparam int CW = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(STABLE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);

    logic [DIGITS-1:0]   s_sel;
    logic [7:0]          s_seg;
    logic [CW-1:0]       cnt;
    logic [DIGITS-1:0]   seen;
    logic [4*DIGITS-1:0] sh_val;
    logic [DIGITS-1:0]   sh_dp;
    logic [DIGITS-1:0]   sh_err;

    logic                same;
    logic                capture;
    logic                publish;
    logic [3:0]          dec_nib;
    logic                dec_err;
    logic [DIGITS-1:0]   seen_n;
    logic [4*DIGITS-1:0] sh_val_n;
    logic [DIGITS-1:0]   sh_dp_n;
    logic [DIGITS-1:0]   sh_err_n;

    assign same    = (digit_sel == s_sel) && (segments == s_seg);
    // Capture exactly once, on the edge the count saturates, and only for a single selected digit.
    assign capture = !clear && same && (cnt == CNT_LAST) && $onehot(s_sel);
    assign publish = capture && (&seen_n);

    // Map the held segment pattern back to its hex nibble; unknown patterns flag an error.
    always_comb begin
        dec_nib = 4'h0;
        dec_err = 1'b0;
        case (s_seg[6:0])
            7'h3F: dec_nib = 4'h0;
            7'h06: dec_nib = 4'h1;
            7'h5B: dec_nib = 4'h2;
            7'h4F: dec_nib = 4'h3;
            7'h66: dec_nib = 4'h4;
            7'h6D: dec_nib = 4'h5;
            7'h7D: dec_nib = 4'h6;
            7'h07: dec_nib = 4'h7;
            7'h7F: dec_nib = 4'h8;
            7'h6F: dec_nib = 4'h9;
            7'h77: dec_nib = 4'hA;
            7'h7C: dec_nib = 4'hB;
            7'h39: dec_nib = 4'hC;
            7'h5E: dec_nib = 4'hD;
            7'h79: dec_nib = 4'hE;
            7'h71: dec_nib = 4'hF;
            default: dec_err = 1'b1;
        endcase
    end

    // Next shadow contents with the captured digit merged in, so publish sees it on the same edge.
    always_comb begin
        seen_n   = seen;
        sh_val_n = sh_val;
        sh_dp_n  = sh_dp;
        sh_err_n = sh_err;
        if (capture) begin
            for (int i = 0; i < DIGITS; i++) begin
                if (s_sel[i]) begin
                    sh_val_n[4*i +: 4] = dec_nib;
                    sh_dp_n[i]         = s_seg[7];
                    sh_err_n[i]        = dec_err;
                    seen_n[i]          = 1'b1;
                end
            end
        end
    end

    // Input sampling and stability counting; clear restarts the settle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_sel <= '0;
            s_seg <= '0;
            cnt   <= '0;
        end else begin
            s_sel <= digit_sel;
            s_seg <= segments;
            if (clear || !same) begin
                cnt <= '0;
            end else if (cnt < CNT_MAX) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    // Frame assembly: shadow slots, seen mask, and the registered published frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seen      <= '0;
            sh_val    <= '0;
            sh_dp     <= '0;
            sh_err    <= '0;
            value     <= '0;
            dp        <= '0;
            err_digit <= '0;
            valid     <= 1'b0;
        end else begin
            valid <= 1'b0;
            if (clear) begin
                seen <= '0;
            end else begin
                sh_val <= sh_val_n;
                sh_dp  <= sh_dp_n;
                sh_err <= sh_err_n;
                if (publish) begin
                    value     <= sh_val_n;
                    dp        <= sh_dp_n;
                    err_digit <= sh_err_n;
                    seen      <= '0;
                    valid     <= 1'b1;
                end else begin
                    seen <= seen_n;
                end
            end
        end
    end

endmodule

// File: tb/tb_seven_segment_reader.sv
// tb/tb_seven_segment_reader.sv - self-checking bench for seven_segment_reader
module tb_seven_segment_reader;

    localparam int ND = 4;
    localparam int ST = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [7:0]    segments = '0;
    logic [ND-1:0] digit_sel = '0;
    logic          clear = 1'b0;
    logic [4*ND-1:0] value;
    logic [ND-1:0] dp;
    logic [ND-1:0] err_digit;
    logic          valid;

    seven_segment_reader #(.DIGITS(ND), .STABLE_CYCLES(ST)) dut (
        .clk(clk), .rst_n(rst_n), .segments(segments), .digit_sel(digit_sel),
        .clear(clear), .value(value), .dp(dp), .err_digit(err_digit), .valid(valid)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int pulses  = 0;

    logic [6:0] seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    // reference model: how long the current input has been held, what this frame has collected
    logic [11:0]     m_last;
    int              m_held;
    logic [ND-1:0]   m_seen;
    logic [3:0]      m_nib [ND];
    logic [ND-1:0]   m_dp, m_err;
    logic [4*ND-1:0] e_value;
    logic [ND-1:0]   e_dp, e_err;
    logic            e_valid;

    task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_last = '0; m_held = 0; m_seen = '0; m_dp = '0; m_err = '0;
        for (int k = 0; k < ND; k++) m_nib[k] = 4'h0;
        e_value = '0; e_dp = '0; e_err = '0; e_valid = 1'b0;
    endtask

    task automatic model_edge(input logic [ND-1:0] sel, input logic [7:0] seg, input logic clr);
        logic [11:0] cur;
        int idx;
        logic [3:0] nib;
        logic bad;
        cur = {sel, seg};
        e_valid = 1'b0;
        if (clr) begin
            m_held = 0;
            m_seen = '0;
        end else if (cur != m_last) begin
            m_held = 0;
        end else if (m_held < ST) begin
            m_held++;
            if (m_held == ST && $countones(sel) == 1) begin
                idx = 0;
                for (int k = 0; k < ND; k++) if (sel[k]) idx = k;
                nib = 4'h0; bad = 1'b1;
                for (int k = 0; k < 16; k++) if (seg_tab[k] == seg[6:0]) begin nib = 4'(k); bad = 1'b0; end
                m_nib[idx] = nib; m_dp[idx] = seg[7]; m_err[idx] = bad; m_seen[idx] = 1'b1;
                if (&m_seen) begin
                    for (int k = 0; k < ND; k++) e_value[4*k +: 4] = m_nib[k];
                    e_dp = m_dp; e_err = m_err; e_valid = 1'b1; m_seen = '0;
                end
            end
        end
        m_last = cur;
    endtask

    task automatic check_all(input string tag);
        cmp({tag, ".valid"}, 32'(valid), 32'(e_valid));
        cmp({tag, ".value"}, 32'(value), 32'(e_value));
        cmp({tag, ".dp"}, 32'(dp), 32'(e_dp));
        cmp({tag, ".err"}, 32'(err_digit), 32'(e_err));
    endtask

    task automatic step(input logic [ND-1:0] sel, input logic [7:0] seg, input logic clr);
        digit_sel = sel; segments = seg; clear = clr;
        @(posedge clk);
        model_edge(sel, seg, clr);
        #1;
        if (valid === 1'b1) pulses++;
        check_all("cycle");
    endtask

    task automatic hold(input logic [ND-1:0] sel, input logic [7:0] seg, input int n);
        repeat (n) step(sel, seg, 1'b0);
    endtask

    initial begin
        logic [ND-1:0] rsel;
        logic [7:0] rseg;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        cmp("reset.value", 32'(value), 32'h0);
        cmp("reset.valid", 32'(valid), 32'h0);
        rst_n = 1'b1;

        // basic frame with explicit latency check on the last digit
        pulses = 0;
        hold(4'b0001, 8'h3F, 6); hold(4'b0010, 8'h06, 6); hold(4'b0100, 8'h5B, 6);
        hold(4'b1000, 8'h4F, 4);
        cmp("basic.early", 32'(pulses), 32'd0);
        step(4'b1000, 8'h4F, 1'b0);
        cmp("basic.valid_e4", 32'(valid), 32'h1);
        step(4'b1000, 8'h4F, 1'b0);
        cmp("basic.pulses", 32'(pulses), 32'd1);
        cmp("basic.value", 32'(value), 32'h3210);
        cmp("basic.dp", 32'(dp), 32'h0);
        cmp("basic.err", 32'(err_digit), 32'h0);
        hold(4'b0000, 8'h00, 1);

        // hex digits with decimal point
        hold(4'b0001, 8'hF1, 6); hold(4'b0010, 8'h79, 6); hold(4'b0100, 8'h5E, 6); hold(4'b1000, 8'h39, 6);
        cmp("hex.value", 32'(value), 32'hCDEF);
        cmp("hex.dp", 32'(dp), 32'h1);
        cmp("hex.err", 32'(err_digit), 32'h0);

        // glitch and illegal selects
        pulses = 0;
        hold(4'b0001, 8'h06, 3); hold(4'b0011, 8'h06, 10); hold(4'b0000, 8'h06, 10);
        cmp("glitch.pulses", 32'(pulses), 32'd0);
        cmp("glitch.value", 32'(value), 32'hCDEF);
        hold(4'b0001, 8'h6D, 6); hold(4'b0010, 8'h7D, 6); hold(4'b0100, 8'h07, 6); hold(4'b1000, 8'h7F, 6);
        cmp("glitch.after", 32'(value), 32'h8765);
        cmp("glitch.after_pulses", 32'(pulses), 32'd1);

        // non-code pattern on digit 2
        hold(4'b0001, 8'h06, 6); hold(4'b0010, 8'h5B, 6); hold(4'b0100, 8'h7E, 6); hold(4'b1000, 8'h4F, 6);
        cmp("inval.value", 32'(value), 32'h3021);
        cmp("inval.err", 32'(err_digit), 32'h4);

        // clear on the completing capture edge
        pulses = 0;
        hold(4'b0001, 8'h3F, 6); hold(4'b0010, 8'h3F, 6); hold(4'b0100, 8'h3F, 6);
        hold(4'b1000, 8'h3F, 4);
        step(4'b1000, 8'h3F, 1'b1);
        hold(4'b0000, 8'h00, 2);
        cmp("clear.pulses", 32'(pulses), 32'd0);
        hold(4'b0001, 8'h06, 6); hold(4'b0010, 8'h5B, 6); hold(4'b0100, 8'h4F, 6);
        cmp("clear.held", 32'(value), 32'h3021);
        hold(4'b1000, 8'h66, 6);
        cmp("clear.value", 32'(value), 32'h4321);
        cmp("clear.pulses2", 32'(pulses), 32'd1);

        // asynchronous reset mid-frame
        hold(4'b0001, 8'h7F, 6); hold(4'b0010, 8'h7F, 6); hold(4'b0100, 8'h7F, 2);
        rst_n = 1'b0;
        #1;
        cmp("arst.value", 32'(value), 32'h0);
        cmp("arst.dp", 32'(dp), 32'h0);
        cmp("arst.err", 32'(err_digit), 32'h0);
        cmp("arst.valid", 32'(valid), 32'h0);
        model_reset();
        #1 rst_n = 1'b1;
        pulses = 0;
        hold(4'b0100, 8'h7F, 6); hold(4'b1000, 8'h7F, 6);
        cmp("arst.pulses", 32'(pulses), 32'd0);

        // randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            int r;
            r = int'($urandom_range(0, 9));
            if (r < 7) rsel = 4'(4'b0001 << $urandom_range(0, 3));
            else if (r == 7) rsel = 4'b0000;
            else rsel = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 5) == 0) rseg = 8'($urandom_range(0, 255));
            else rseg = {1'($urandom_range(0, 1)), seg_tab[$urandom_range(0, 15)]};
            if ($urandom_range(0, 30) == 0) step(rsel, rseg, 1'b1);
            hold(rsel, rseg, int'($urandom_range(1, 8)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
